mul_ctrl: RTL and testbench

MUL_CTRL -- requirements
Module: mul_ctrl

---
 rtl/mul_pkg.sv | 22 ++
 rtl/mul_step.sv | 25 ++
 rtl/mul_ctrl.sv | 134 +++++++++++++
 tb/tb_mul_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the default operand width, the controller state encoding and
// the iteration counter width.
package mul_pkg;

   localparam int MUL_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } mul_state_e;

   // The counter must reach WIDTH-1 and also hold the remaining-shift
   // arithmetic, hence one bit more than log2 of the width.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

   localparam int MUL_CNT_W = cnt_width(MUL_WIDTH);

endpackage

// File: rtl/mul_step.sv
// One combinational shift-add iteration of the unsigned multiplier.
// The accumulator holds {partial product, unprocessed multiplier bits};
// the add may carry out of the upper half and that carry is shifted back in.
module mul_step
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   mcand_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [WIDTH:0] upper;

   // Conditionally add the multiplicand to the upper half, then shift right
   always_comb begin
      upper = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
      if (acc_i[0]) begin
         upper = upper + {1'b0, mcand_i};
      end
      acc_o = {upper, acc_i[WIDTH-1:1]};
   end

endmodule

// File: rtl/mul_ctrl.sv
// Multi-cycle signed/unsigned multiplier controller.
// Operands are captured as magnitudes, multiplied by mul_step one bit per
// RUN cycle, and the sign is restored when the product is written to hi/lo.
// Optional macro MUL_EARLY_TERM_EN ends RUN once the remaining multiplier
// bits are all zero and right-aligns the partial product accordingly.
module mul_ctrl
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CntW = cnt_width(WIDTH);

   mul_state_e         state_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   mcand_q;
   logic [CntW-1:0]    cnt_q;
   logic               neg_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
`ifdef MUL_EARLY_TERM_EN
   logic [WIDTH-2:0]   rem_q;
   logic [CntW-1:0]    shamt;
`endif

   logic               startOk;
   logic               lastStep;
   logic [WIDTH-1:0]   absA;
   logic [WIDTH-1:0]   absB;
   logic [2*WIDTH-1:0] aligned;
   logic [2*WIDTH-1:0] result;

   mul_step #(.WIDTH(WIDTH)) u_step (
      .acc_i   (acc_q),
      .mcand_i (mcand_q),
      .acc_o   (acc_d)
   );

   // Operand magnitudes, termination test and sign-corrected final product
   always_comb begin
      startOk = start && !flush;
      absA    = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
      absB    = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
`ifdef MUL_EARLY_TERM_EN
      lastStep = (cnt_q == CntW'(WIDTH - 1)) || (rem_q == '0);
      shamt    = CntW'(WIDTH - 1) - cnt_q;
      aligned  = acc_d >> shamt;
`else
      lastStep = (cnt_q == CntW'(WIDTH - 1));
      aligned  = acc_d;
`endif
      result = neg_q ? (~aligned + 1'b1) : aligned;
   end

   // Controller FSM with datapath registers and registered busy/done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MUL_EARLY_TERM_EN
         rem_q   <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, FIN: begin
               busy_q <= startOk;
               if (startOk) begin
                  state_q <= RUN;
                  mcand_q <= absA;
                  acc_q   <= {{WIDTH{1'b0}}, absB};
                  cnt_q   <= '0;
                  neg_q   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MUL_EARLY_TERM_EN
                  rem_q   <= absB[WIDTH-1:1];
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               if (flush) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (lastStep) begin
                  state_q <= FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  hi_q    <= result[2*WIDTH-1:WIDTH];
                  lo_q    <= result[WIDTH-1:0];
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + 1'b1;
`ifdef MUL_EARLY_TERM_EN
                  rem_q <= rem_q >> 1;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: directed operand vectors with
// hand-computed products, a scoreboard queue of expected results and a
// monitor that checks every done pulse. Honours MUL_EARLY_TERM_EN.
module tb_mul_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t expQ[$];
   int   cyc;
   int   vectors;
   int   miscompares;

   mul_ctrl #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle index: a start driven while cyc==c is sampled at the end of cycle c
   initial cyc = 0;
   always @(posedge clk) cyc++;

   // Shared comparison point for every check in the bench
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   // Number of RUN cycles expected for a given multiplier magnitude
   function automatic int nRun(input logic [31:0] bAbs);
      int n;
      n = 32;
`ifdef MUL_EARLY_TERM_EN
      n = 1;
      for (int i = 0; i < 32; i++) begin
         if (bAbs[i]) n = i + 1;
      end
`endif
      return n;
   endfunction

   function automatic logic [31:0] magB(input logic [31:0] bv, input logic sgn);
      return (sgn && bv[31]) ? (~bv + 32'd1) : bv;
   endfunction

   // Monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("product", {hi, lo}, {e.hi, e.lo});
            checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Issue one multiply for a single cycle and queue its expected result
   task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                input logic sgn, input logic [31:0] eHi,
                                input logic [31:0] eLo);
      exp_t e;
      @(negedge clk);
      start     = 1'b1;
      a         = av;
      b         = bv;
      is_signed = sgn;
      e.hi  = eHi;
      e.lo  = eLo;
      e.cyc = cyc + nRun(magB(bv, sgn)) + 1;
      expQ.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Bounded wait until every queued result has been seen
   task automatic waitDrain();
      for (int i = 0; i < 200 && expQ.size() > 0; i++) @(negedge clk);
      checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
   endtask

   initial begin
      int c;
      int n1;
      int fl;
      exp_t e;
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      is_signed   = 1'b0;
      a           = '0;
      b           = '0;
      flush       = 1'b0;

      #2;
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_hilo", {hi, lo}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Unsigned all-ones squared, with busy window checks
      @(negedge clk);
      c = cyc;
      start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; is_signed = 1'b0;
      e.hi = 32'hFFFF_FFFE; e.lo = 32'h0000_0001; e.cyc = c + 33;
      expQ.push_back(e);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_first_run_cycle", 64'(busy), 64'd1);
      repeat (31) @(negedge clk);
      checkOutput("busy_last_run_cycle", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("busy_in_fin", 64'(busy), 64'd0);
      waitDrain();

      // Signed and unsigned interpretations of the same bits
      applyStimulus(32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      waitDrain();
      applyStimulus(32'hFFFF_FFFD, 32'd5, 1'b0, 32'h0000_0004, 32'hFFFF_FFF1);
      waitDrain();
      applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
      waitDrain();
      applyStimulus(32'h8000_0000, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
      waitDrain();

      // Short multipliers and the zero multiplier
      applyStimulus(32'd7, 32'd3, 1'b0, 32'd0, 32'd21);
      waitDrain();
      applyStimulus(32'h0000_1234, 32'd0, 1'b0, 32'd0, 32'd0);
      waitDrain();
      applyStimulus(32'd1, 32'h8000_0000, 1'b0, 32'd0, 32'h8000_0000);
      waitDrain();

      // Flush mid-RUN: no done, result registers keep 0x80000000
`ifdef MUL_EARLY_TERM_EN
      fl = 2;
`else
      fl = 10;
`endif
      @(negedge clk);
      c = cyc;
      start = 1'b1; a = 32'd7; b = 32'd9; is_signed = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c + fl) @(negedge clk);
      checkOutput("busy_before_flush", 64'(busy), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("busy_after_flush", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);
      checkOutput("hilo_kept_after_flush", {hi, lo}, {32'd0, 32'h8000_0000});

      // Start together with flush is dropped
      @(negedge clk);
      start = 1'b1; flush = 1'b1; a = 32'd5; b = 32'd5;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("busy_start_with_flush", 64'(busy), 64'd0);
         @(negedge clk);
      end

      // Start held through RUN is ignored, then accepted in the FIN cycle
      @(negedge clk);
      c = cyc;
      n1 = nRun(32'd100);
      start = 1'b1; a = 32'd12345; b = 32'd100; is_signed = 1'b0;
      e.hi = 32'd0; e.lo = 32'h0012_D644; e.cyc = c + n1 + 1;
      expQ.push_back(e);
      @(negedge clk);
      a = 32'hFFFF_FFFE; b = 32'hFFFF_FFF9; is_signed = 1'b1;
      e.hi = 32'd0; e.lo = 32'd14; e.cyc = c + n1 + 1 + nRun(32'd7) + 1;
      expQ.push_back(e);
      while (cyc < c + n1 + 1) @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_fin_start", 64'(busy), 64'd1);
      waitDrain();

      // Asynchronous reset mid-RUN clears everything and yields no done
      @(negedge clk);
      start = 1'b1; a = 32'd3; b = 32'hFFFF_FFFF; is_signed = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_busy", 64'(busy), 64'd0);
      checkOutput("async_reset_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("done_after_reset", 64'(done), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
